uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Next-generation UART receiver that turns serial `rxd` into an AXI-Stream word stream.
- Samples each bit as a 3-sample majority vote at mid-bit, after a `rxd` synchroniser.
- Frame format (data bits, parity, stop bits) is configurable at run time.
- Received words are buffered in an output FIFO, with per-word error flags and a sticky overrun flag.
- Sits between the pad `rxd` and the host-side stream consumer; replaces the single-register receiver.

Parameters:
- DATA_W, 8: maximum data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16: output FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: flip-flops in the `rxd` synchroniser; at least 2.

Ports:
- clk  in  1: clock.
- rst  in  1: reset; asynchronous, active-high.
- rxd  in  1: serial input; idles high.
- prescale  in  16: clocks per bit; values below 8 are treated as 8.
- cfg_data_bits  in  4: data bits per frame; below 5 is treated as 5, above DATA_W as DATA_W.
- cfg_parity  in  3: 0 NONE, 1 ODD, 2 EVEN, 3 MARK, 4 SPACE; 5..7 are treated as NONE.
- cfg_stop_bits  in  1: 0 means one stop bit, 1 means two.
- m_axis_tdata  out  DATA_W: received data, right-aligned; upper unused bits are 0.
- m_axis_tuser  out  3: {break, parity_err, frame_err} belonging to the same word.
- m_axis_tvalid  out  1: FIFO not empty.
- m_axis_tready  in  1: consumer accept.
- fifo_level  out  $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- busy  out  1: high whenever the receiver FSM is not in IDLE.
- overrun  out  1: sticky; set when a word is dropped because the FIFO is full.
- overrun_clr  in  1: one-cycle pulse that clears `overrun`.

Behaviour:
- Reset (asynchronous): all outputs are 0; FIFO empty; FSM in IDLE; synchroniser preset to 1.
- Synchroniser: `rxd` passes through SYNC_STAGES flops, giving `rxs`.
- Start detect: only a 1→0 transition of `rxs` while in IDLE starts a frame. A line held low from reset is ignored until it has been seen high.
- Config latching: at start detect, `prescale`, `cfg_data_bits`, `cfg_parity` and `cfg_stop_bits` are latched. Changes mid-frame have no effect.
- Bit counter: a 16-bit down-counter counts clocks per bit period. The mid-bit point is count P/2, where P is the latched prescale.
  - Samples at P/2−1, P/2 and P/2+1 are majority-voted into the bit value.
- FSM: IDLE → START → DATA → PARITY (skipped when NONE) → STOP → IDLE.
- START: a voted value of 1 at mid-start means a glitch; return to IDLE with no write. Otherwise go to DATA when the period ends.
- DATA: bits arrive LSB first; after N voted bits go to PARITY or STOP.
- PARITY: compare the voted bit with the expected value:
  - ODD: ~^data.
  - EVEN: ^data.
  - MARK: 1.
  - SPACE: 0.
  - Any mismatch sets parity_err.
- STOP: any stop bit voted 0 sets frame_err.
  - The FIFO write happens 1 cycle after the voted sample of the last stop bit; the FSM returns to IDLE on that same cycle.
  - The FSM does not wait for the end of the stop bit, so it can resync on the next start edge.
- Break: set when all data bits, the parity bit (if present) and all stop bits are 0. frame_err is also set in that case.
- FIFO write, FIFO full: the word is dropped and `overrun` is set that cycle. If a set and `overrun_clr` occur in the same cycle, set wins.
- FIFO write, FIFO not full: the entry {tuser, tdata} is pushed.
- FIFO output: registered. `m_axis_tvalid` rises exactly 2 cycles after the last-stop voted-sample edge when the FIFO was empty.
- Pop: on tvalid && tready.
- Simultaneous push and pop: allowed, including when full. The level is unchanged, and the pop frees space for the push in that same cycle, so no overrun.
- `fifo_level` wraps correctly across the pointer wrap-around; the FIFO keeps an extra pointer bit.
- Reset mid-frame: the frame is discarded, the FIFO is flushed, and no word is emitted.

Decomposition:
- Package `uart_pkg` holds:
  - the parity mode constants (PAR_NONE..PAR_SPACE);
  - the FSM state enum;
  - tuser bit indices (TU_FERR=0, TU_PERR=1, TU_BRK=2);
  - the minimum prescale constant MIN_PRESCALE=8.
- Sub-module `uart_sync_fifo` is a parametrised width/depth FIFO with level output. It is also reusable by the future TX path.

Test Plan:
- 8N1, prescale=16, send 0xA5 → one word: tdata=0xA5, tuser=000, tvalid rising 2 clk after the mid-stop sample.
- 7E1 0x41 with correct parity 0, then flipped parity 1 → tdata=0x41 with tuser=000, then tdata=0x41 with tuser=010.
- 8N1: a 3-clk low glitch on idle `rxd` yields no word and busy returns to 0; a single-clk glitch at mid-data bit 3 of 0x00 still gives tdata=0x00.
- 8N2 frame with the second stop bit 0 → tuser=001. An all-zero frame (with the stop bit 0) gives tdata=0x00, tuser=101.
- FIFO_DEPTH=4, tready=0, send 5 words → fifo_level=4, overrun=1, and words 1..4 are read back in order after tready=1. Pulsing overrun_clr then clears the flag.
- Assert rst during DATA of a frame → tvalid=0 and busy=0 immediately. With `rxd` held low after release, no word appears. The next valid 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path (and the future TX path).
// Holds parity mode encodings, the receiver FSM states and the tuser flag bit positions.
package uart_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_EVEN  = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int TU_FERR = 0;
    localparam int TU_PERR = 1;
    localparam int TU_BRK  = 2;

    localparam logic [15:0] MIN_PRESCALE = 16'd8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read outputs; a write becomes visible on rd_vld two edges later.
// Backpressure: wr_rdy drops only when full with no pop in the same cycle; a pop frees space for a simultaneous push.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      rptr_nxt;
    logic             push;
    logic             pop;
    logic             nxt_vld;

    // Pointers carry one extra bit so full and empty stay distinguishable across wrap.
    assign level    = wptr - rptr;
    assign pop      = rd_vld & rd_rdy;
    assign wr_rdy   = (level != FULL_LVL) | pop;
    assign push     = wr_vld & wr_rdy;
    assign rptr_nxt = rptr + {{AW{1'b0}}, pop};
    assign nxt_vld  = (wptr != rptr_nxt);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wr_dat;
        end
    end

    // Output stage looks at the pre-push write pointer, so the head slot never aliases the slot being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + {{AW{1'b0}}, 1'b1};
            end
            rptr   <= rptr_nxt;
            rd_vld <= nxt_vld;
            rd_dat <= nxt_vld ? mem[rptr_nxt[AW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with 3-sample mid-bit voting, run-time frame format and an AXI-Stream output FIFO.
// Word pushed 1 clk after the last stop vote, tvalid 2 clk after it; a full FIFO drops the word and sets overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic [15:0]                   prescale,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [2:0]                    cfg_parity,
    input  logic                          cfg_stop_bits,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [2:0]                    m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          overrun_clr
);
    localparam logic [3:0] MAX_BITS = 4'(DATA_W);
    localparam logic [3:0] MIN_BITS = 4'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic                   rxs;
    logic                   rxs_prev;
    logic                   start_edge;

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [15:0] p_eff;
    logic [3:0]  nb_eff;
    logic [2:0]  par_eff;
    logic [15:0] p_q;
    logic [3:0]  nb_q;
    logic [2:0]  par_q;
    logic        stop2_q;
    logic [15:0] cnt;
    logic [15:0] half;
    logic [3:0]  bit_idx;
    logic        stop_idx;
    logic        s_a;
    logic        s_b;
    logic        samp_a;
    logic        samp_b;
    logic        vote_pt;
    logic        bit_end;
    logic        vote;
    logic        last_stop;
    logic        last_data;
    logic        exp_par;
    logic        frame_done;
    logic [DATA_W-1:0] data_q;
    logic        perr_q;
    logic        ferr_q;
    logic        zeros_q;
    logic [2:0]  tuser_nxt;
    logic        push_q;
    logic [DATA_W+2:0] word_q;
    logic [DATA_W+2:0] rd_word;
    logic        fifo_wr_rdy;

    // sync_vld tracks which synchroniser stages hold real line samples, so the reset
    // preset of 1 is never mistaken for an idle line before a falling edge.
    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '1;
            sync_vld <= '0;
            rxs_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            rxs_prev <= rxs & sync_vld[SYNC_STAGES-1];
        end
    end

    assign start_edge = rxs_prev & ~rxs;

    always_comb begin
        p_eff   = (prescale < MIN_PRESCALE) ? MIN_PRESCALE : prescale;
        nb_eff  = (cfg_data_bits < MIN_BITS) ? MIN_BITS :
                  (cfg_data_bits > MAX_BITS) ? MAX_BITS : cfg_data_bits;
        par_eff = (cfg_parity > PAR_SPACE) ? PAR_NONE : cfg_parity;
    end

    // Down-counter runs P-1..0 per bit; samples at P/2+1, P/2, P/2-1, vote resolves on the last.
    assign half      = {1'b0, p_q[15:1]};
    assign samp_a    = (cnt == half + 16'd1);
    assign samp_b    = (cnt == half);
    assign vote_pt   = (cnt == half - 16'd1);
    assign bit_end   = (cnt == 16'd0);
    assign vote      = maj3(s_a, s_b, rxs);
    assign last_stop = (stop_idx == stop2_q);
    assign last_data = (bit_idx == nb_q - 4'd1);

    always_comb begin
        exp_par = 1'b0;
        case (par_q)
            PAR_ODD:  exp_par = ~^data_q;
            PAR_EVEN: exp_par = ^data_q;
            PAR_MARK: exp_par = 1'b1;
            default:  exp_par = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:   if (start_edge) state_nxt = ST_START;
            ST_START: begin
                if (vote_pt && vote) state_nxt = ST_IDLE;
                else if (bit_end)    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_data) state_nxt = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            ST_STOP: begin
                if (vote_pt && last_stop) begin
                    state_nxt  = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tuser_nxt          = '0;
        tuser_nxt[TU_BRK]  = zeros_q & ~vote;
        tuser_nxt[TU_PERR] = perr_q;
        tuser_nxt[TU_FERR] = ferr_q | ~vote;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= '0;
            nb_q     <= '0;
            par_q    <= '0;
            stop2_q  <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            s_a      <= 1'b0;
            s_b      <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            zeros_q  <= 1'b0;
            push_q   <= 1'b0;
            word_q   <= '0;
        end else begin
            push_q <= frame_done;
            if (frame_done) begin
                word_q <= {tuser_nxt, data_q};
            end
            if (state == ST_IDLE) begin
                if (start_edge) begin
                    p_q      <= p_eff;
                    nb_q     <= nb_eff;
                    par_q    <= par_eff;
                    stop2_q  <= cfg_stop_bits;
                    cnt      <= p_eff - 16'd1;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    data_q   <= '0;
                    perr_q   <= 1'b0;
                    ferr_q   <= 1'b0;
                    zeros_q  <= 1'b1;
                end
            end else begin
                cnt <= bit_end ? (p_q - 16'd1) : (cnt - 16'd1);
                if (samp_a) s_a <= rxs;
                if (samp_b) s_b <= rxs;
                if (vote_pt && (state != ST_START)) begin
                    zeros_q <= zeros_q & ~vote;
                end
                if (vote_pt) begin
                    case (state)
                        ST_DATA:   data_q <= data_q | (DATA_W'(vote) << bit_idx);
                        ST_PARITY: perr_q <= vote ^ exp_par;
                        ST_STOP:   if (!vote) ferr_q <= 1'b1;
                        default:   ;
                    endcase
                end
                if (bit_end && (state == ST_DATA)) bit_idx  <= bit_idx + 4'd1;
                if (bit_end && (state == ST_STOP)) stop_idx <= 1'b1;
            end
        end
    end

    // A set and a clear in the same cycle leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         overrun <= 1'b0;
        else if (push_q && !fifo_wr_rdy) overrun <= 1'b1;
        else if (overrun_clr)            overrun <= 1'b0;
    end

    uart_sync_fifo #(
        .WIDTH (DATA_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_q),
        .wr_dat (word_q),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (m_axis_tvalid),
        .rd_dat (rd_word),
        .rd_rdy (m_axis_tready),
        .level  (fifo_level)
    );

    assign {m_axis_tuser, m_axis_tdata} = rd_word;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: hand-built serial frames, expected words and flags written out per step.
module tb_uart_rx_os;
    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rxd = 1'b1;
    logic [15:0]       prescale = 16'd16;
    logic [3:0]        cfg_data_bits = 4'd8;
    logic [2:0]        cfg_parity = 3'd0;
    logic              cfg_stop_bits = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [2:0]        m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [LW-1:0]     fifo_level;
    logic              busy;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    int   ntests   = 0;
    int   nfail    = 0;
    int   cyc      = 0;
    int   c0       = 0;
    int   rise_cyc = -1;
    logic tv_q     = 1'b0;

    uart_rx_os #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop_bits (cfg_stop_bits),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_axis_tvalid && !tv_q) rise_cyc <= cyc;
        tv_q <= m_axis_tvalid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge; one bit lasts p clocks.
    task automatic drive_bit(input logic b, input int p, input bit glitch);
        rxd = b;
        if (glitch) begin
            repeat (p / 2) @(posedge clk);
            #1 rxd = ~b;
            @(posedge clk);
            #1 rxd = b;
            repeat (p - p / 2 - 1) @(posedge clk);
        end else begin
            repeat (p) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par, input logic par_bit,
                              input int ns, input logic s0, input logic s1, input int p, input int gbit);
        @(posedge clk);
        #1;
        c0 = cyc;
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i], p, (i == gbit));
        if (has_par) drive_bit(par_bit, p, 1'b0);
        drive_bit(s0, p, 1'b0);
        if (ns == 2) drive_bit(s1, p, 1'b0);
        drive_bit(1'b1, p, 1'b0);
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d, input logic [2:0] u);
        for (int i = 0; i < 400 && m_axis_tvalid !== 1'b1; i++) @(negedge clk);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_tdata"},  32'(m_axis_tdata),  32'(d));
        check({tag, "_tuser"},  32'(m_axis_tuser),  32'(u));
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_level",   32'(fifo_level),    32'd0);
        check("rst_overrun", 32'(overrun),       32'd0);
        check("rst_tdata",   32'(m_axis_tdata),  32'd0);
        check("rst_tuser",   32'(m_axis_tuser),  32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // 8N1 0xA5 at 16 clk/bit; last stop vote edge is 2+1+9+9*16 = 156 clocks after the start drive.
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        check("a5_latency", 32'(rise_cyc - c0), 32'd158);
        check("a5_level",   32'(fifo_level),    32'd1);
        expect_word("a5", 8'hA5, 3'b000);
        check("a5_drained", 32'(fifo_level),    32'd0);

        // 7E1 with prescale below the floor: the line runs at 8 clk/bit.
        prescale      = 16'd3;
        cfg_data_bits = 4'd7;
        cfg_parity    = 3'd2;
        send_frame(9'h041, 7, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8, -1);
        send_frame(9'h041, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1, 8, -1);
        expect_word("7e1_ok",  8'h41, 3'b000);
        expect_word("7e1_bad", 8'h41, 3'b010);

        // 3-clock low glitch on an idle line.
        prescale      = 16'd16;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_lo", 32'(busy),          32'd0);
        check("glitch_level",   32'(fifo_level),    32'd0);
        check("glitch_tvalid",  32'(m_axis_tvalid), 32'd0);

        send_frame(9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, 3);
        expect_word("mid_glitch", 8'h00, 3'b000);

        cfg_stop_bits = 1'b1;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16, -1);
        expect_word("stop2_zero", 8'h5A, 3'b001);
        cfg_stop_bits = 1'b0;
        send_frame(9'h000, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1, 16, -1);
        expect_word("break", 8'h00, 3'b101);

        // Five words into a 4-deep FIFO with the consumer stalled.
        prescale = 16'd8;
        for (int i = 1; i <= 5; i++) send_frame(9'(i * 17), 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8, -1);
        check("ovr_level", 32'(fifo_level), 32'd4);
        check("ovr_flag",  32'(overrun),    32'd1);
        for (int i = 1; i <= 4; i++) expect_word($sformatf("ovr_w%0d", i), 8'(i * 17), 3'b000);
        check("ovr_empty",  32'(m_axis_tvalid), 32'd0);
        check("ovr_lvl0",   32'(fifo_level),    32'd0);
        check("ovr_sticky", 32'(overrun),       32'd1);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Reset in the middle of a data bit with a word already waiting.
        prescale = 16'd16;
        send_frame(9'h077, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        @(posedge clk);
        #1;
        drive_bit(1'b0, 16, 1'b0);
        drive_bit(1'b0, 16, 1'b0);
        drive_bit(1'b0, 16, 1'b0);
        drive_bit(1'b1, 16, 1'b0);
        check("pre_rst_busy",   32'(busy),          32'd1);
        check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        rxd = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rstmid_busy",   32'(busy),          32'd0);
        check("rstmid_level",  32'(fifo_level),    32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        check("low_after_rst_busy",   32'(busy),          32'd0);
        check("low_after_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        rxd = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        expect_word("post_rst", 8'h3C, 3'b000);
        check("final_level", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
